shift_rows_pipe: RTL and testbench
==================================

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 The block SHALL have parameter NB, default 4, meaning state columns (Rijndael Nb); legal values are 4, 6 and 8, and any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter W, default 32*NB, meaning state width in bits; it is derived only and SHALL NOT be overridden.
REQ-003 The block SHALL have port pi_clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port pi_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port pi_valid, input, 1 bit: an input state is offered.
REQ-006 The block SHALL have port po_ready, output, 1 bit: the block accepts the input state.
REQ-007 The block SHALL have port pi_inv, input, 1 bit: 0 selects ShiftRows, 1 selects InvShiftRows; it is sampled with pi_in.
REQ-008 The block SHALL have port pi_in, input, W bits: input state.
REQ-009 The block SHALL have port po_valid, output, 1 bit: an output state is presented.
REQ-010 The block SHALL have port pi_ready, input, 1 bit: the downstream accepts the output state.
REQ-011 The block SHALL have port po_out, output, W bits: shifted state.
REQ-012 The block SHALL have port po_count, output, 16 bits: the number of states delivered, wrapping modulo 2^16.

Function
REQ-013 The state layout SHALL be row-major with MSB first: row r (0..3) occupies bits [W-1-8*NB*r -: 8*NB], and byte c (0..NB-1) of a row counts from the MSB of that row.
REQ-014 The row offsets s_r SHALL be 0,1,2,3 for NB=4 and NB=6, and 0,1,3,4 for NB=8.
REQ-015 In forward mode (pi_inv=0), output byte (r,c) SHALL equal input byte (r,(c+s_r) mod NB); in inverse mode (pi_inv=1), it SHALL equal input byte (r,(c-s_r+NB) mod NB).
REQ-016 An input transfer SHALL occur on a rising edge where pi_valid=1 and po_ready=1; an output transfer SHALL occur on a rising edge where po_valid=1 and pi_ready=1.
REQ-017 Latency SHALL be 1 cycle: a state accepted at edge N SHALL appear on po_out with po_valid=1 after edge N, when the output stage is empty or draining.
REQ-018 The shift SHALL be computed before the output register, so po_out SHALL be a registered value.
REQ-019 While po_valid=1 and pi_ready=0, po_out and po_valid SHALL hold stable.
REQ-020 States SHALL leave the block in acceptance order, with none dropped or duplicated.
REQ-021 When an input transfer and an output transfer occur on the same edge, the new state SHALL replace the departing one with no bubble, so full throughput is 1 state per cycle.
REQ-022 po_count SHALL increment by 1 on each output transfer and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-023 The data path SHALL contain no state machine beyond the occupancy flags; the occupancy states SHALL be EMPTY, ONE (output register full) and, with skid only, TWO (skid register also full).

Reset
REQ-024 While pi_rst=0, the block SHALL force po_valid=0, po_count=0, po_out=0 and all occupancy flags to EMPTY, regardless of pi_clk.
REQ-025 Reset asserted mid-transfer SHALL discard all held states, and the first accepted state after release SHALL be the first output.
REQ-026 po_ready SHALL be 0 while pi_rst=0.

Configuration
REQ-027 With macro SHIFT_ROWS_SKID_EN defined, the block SHALL include a one-state skid register:
- po_ready SHALL be driven directly from a flop and SHALL equal "skid register empty".
- On the transition ONE->TWO, the state presented while pi_ready=0 SHALL be captured into the skid register.
- While in TWO, that state SHALL be forwarded to the output register on the next output transfer.
REQ-028 Without SHIFT_ROWS_SKID_EN, the block SHALL have a single output register, and po_ready SHALL be the combinational term (po_valid==0 or pi_ready==1).
REQ-029 Both builds SHALL give identical data order, po_out values, po_count and 1-cycle latency.

Verification
REQ-030 With NB=4, pi_inv=0 and pi_in=00010203_04050607_08090A0B_0C0D0E0F, the bench SHALL require po_out=00010203_05060704_0A0B0809_0F0C0D0E one cycle after acceptance.
REQ-031 With NB=4, pi_inv=1 and the same input, the bench SHALL require po_out=00010203_07040506_0A0B0809_0D0E0F0C.
REQ-032 With NB=8, pi_inv=0 and input bytes 00..1F row-major, the bench SHALL require row 2 = 13141516_17101112 and row 3 = 1C1D1E1F_18191A1B.
REQ-033 For a stream of 20 back-to-back states with pi_ready=1, the bench SHALL require po_valid=1 on 20 consecutive cycles, in-order outputs and po_count=20.
REQ-034 For random pi_ready with about 50% stalls, in both the SHIFT_ROWS_SKID_EN build and the default build, the bench SHALL require no loss or duplication, po_out stable during stalls and, in the skid build, po_ready never depending combinationally on pi_ready.
REQ-035 When pi_rst is pulled low while the block holds 2 states, the bench SHALL require po_valid=0 and po_count=0 immediately, and the next accepted state to be the first output after release.

Source files
------------

// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows on a valid/ready pipeline stage with 1-cycle latency.
// Define SHIFT_ROWS_SKID_EN to add a one-state skid register so po_ready comes straight from a flop.
module shift_rows_pipe #(
    parameter int NB = 4,
    parameter int W  = 32*NB
) (
    input  logic         pi_clk,
    input  logic         pi_rst,
    input  logic         pi_valid,
    output logic         po_ready,
    input  logic         pi_inv,
    input  logic [W-1:0] pi_in,
    output logic         po_valid,
    input  logic         pi_ready,
    output logic [W-1:0] po_out,
    output logic [15:0]  po_count
);

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (W != 32*NB) begin : g_bad_w
            $error("shift_rows_pipe: W is derived from NB and must not be overridden");
        end
    endgenerate

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t         occ_reg;
    logic         valid_reg;
    logic [W-1:0] out_reg;
    logic [15:0]  count_reg;
    logic [W-1:0] fwd_next;
    logic [W-1:0] inv_next;
    logic [W-1:0] shift_next;
    logic         in_xfer;
    logic         out_xfer;

    // Byte (r,c) sits at bit W-1-8*NB*r-8*c; the wide state (NB=8) skips offset 2.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            localparam int SR = (NB == 8 && gi >= 2) ? gi + 1 : gi;
            for (genvar gj = 0; gj < NB; gj++) begin : g_col
                localparam int FS = (gj + SR) % NB;
                localparam int IS = (gj - SR + NB) % NB;
                assign fwd_next[W-1-8*NB*gi-8*gj -: 8] = pi_in[W-1-8*NB*gi-8*FS -: 8];
                assign inv_next[W-1-8*NB*gi-8*gj -: 8] = pi_in[W-1-8*NB*gi-8*IS -: 8];
            end
        end
    endgenerate

    assign shift_next = pi_inv ? inv_next : fwd_next;
    assign in_xfer    = pi_valid & po_ready;
    assign out_xfer   = valid_reg & pi_ready;
    assign po_valid   = valid_reg;
    assign po_out     = out_reg;
    assign po_count   = count_reg;

`ifdef SHIFT_ROWS_SKID_EN
    logic [W-1:0] skid_reg;
    logic         ready_reg;

    assign po_ready = ready_reg;

    always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) begin
            occ_reg   <= OCC_EMPTY;
            valid_reg <= 1'b0;
            out_reg   <= '0;
            skid_reg  <= '0;
            ready_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            if (out_xfer) begin
                count_reg <= count_reg + 16'd1;
            end
            case (occ_reg)
                OCC_EMPTY: begin
                    ready_reg <= 1'b1;
                    if (in_xfer) begin
                        out_reg   <= shift_next;
                        valid_reg <= 1'b1;
                        occ_reg   <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        // Downstream stalled while we accepted: park the new state.
                        skid_reg  <= shift_next;
                        ready_reg <= 1'b0;
                        occ_reg   <= OCC_TWO;
                    end else if (in_xfer) begin
                        out_reg <= shift_next;
                    end else if (out_xfer) begin
                        valid_reg <= 1'b0;
                        occ_reg   <= OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (out_xfer) begin
                        out_reg   <= skid_reg;
                        ready_reg <= 1'b1;
                        occ_reg   <= OCC_ONE;
                    end
                end
                default: begin
                    occ_reg   <= OCC_EMPTY;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end
`else
    assign po_ready = pi_rst & (~valid_reg | pi_ready);

    always_ff @(posedge pi_clk or negedge pi_rst) begin
        if (!pi_rst) begin
            occ_reg   <= OCC_EMPTY;
            valid_reg <= 1'b0;
            out_reg   <= '0;
            count_reg <= '0;
        end else begin
            if (out_xfer) begin
                count_reg <= count_reg + 16'd1;
            end
            case (occ_reg)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        out_reg   <= shift_next;
                        valid_reg <= 1'b1;
                        occ_reg   <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer) begin
                        out_reg <= shift_next;
                    end else if (out_xfer) begin
                        valid_reg <= 1'b0;
                        occ_reg   <= OCC_EMPTY;
                    end
                end
                default: begin
                    occ_reg   <= OCC_EMPTY;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: known-answer vectors, streaming, random stalls, reset flush.
// Build with SHIFT_ROWS_SKID_EN defined to also exercise the skid variant.
module tb_shift_rows_pipe;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         pi_rst, pi_valid, pi_inv, pi_ready;
    logic [127:0] pi_in;
    logic         po_ready, po_valid;
    logic [127:0] po_out;
    logic [15:0]  po_count;

    logic         v8_pi_valid, v8_pi_inv, v8_pi_ready;
    logic [255:0] v8_pi_in;
    logic         v8_po_ready, v8_po_valid;
    logic [255:0] v8_po_out;
    logic [15:0]  v8_po_count;

    shift_rows_pipe #(.NB(4)) dut (
        .pi_clk(clk), .pi_rst(pi_rst), .pi_valid(pi_valid), .po_ready(po_ready),
        .pi_inv(pi_inv), .pi_in(pi_in), .po_valid(po_valid), .pi_ready(pi_ready),
        .po_out(po_out), .po_count(po_count)
    );

    shift_rows_pipe #(.NB(8)) dut8 (
        .pi_clk(clk), .pi_rst(pi_rst), .pi_valid(v8_pi_valid), .po_ready(v8_po_ready),
        .pi_inv(v8_pi_inv), .pi_in(v8_pi_in), .po_valid(v8_po_valid), .pi_ready(v8_pi_ready),
        .po_out(v8_po_out), .po_count(v8_po_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!po_ready && n < 8) begin
            tick();
            n++;
        end
        check(tag, po_ready, 1);
    endtask

    // Reference for NB=4: out(r,c) = in(r,(c+r)%4) forward, in(r,(c-r+4)%4) inverse.
    function automatic logic [127:0] ref_shift(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        int src;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int c = 0; c < 4; c++) begin
                src = inv ? (c - row + 4) % 4 : (c + row) % 4;
                r[127-32*row-8*c -: 8] = d[127-32*row-8*src -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] gen_state(input int k);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[127-8*b -: 8] = 8'(k*16 + b*7 + 3);
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] exp_q[$];
        logic [127:0] prev_out;
        logic         prev_stall;
        logic         r0;
        int           sent, recv, cyc;

        pi_rst = 1'b0; pi_valid = 1'b0; pi_inv = 1'b0; pi_ready = 1'b0; pi_in = '0;
        v8_pi_valid = 1'b0; v8_pi_inv = 1'b0; v8_pi_ready = 1'b0; v8_pi_in = '0;
        r0 = 1'b0;
        tick(); tick();
        check("rst_valid", po_valid, 0);
        check("rst_count", po_count, 0);
        check("rst_out",   po_out, 0);
        check("rst_ready", po_ready, 0);

        // Known-answer vectors, forward then inverse
        pi_rst = 1'b1;
        pi_ready = 1'b1;
        tick();
        wait_ready("rdy_after_rst");
        pi_valid = 1'b1; pi_inv = 1'b0;
        pi_in = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        tick();
        pi_valid = 1'b0;
        check("fwd_valid", po_valid, 1);
        check("fwd_out", po_out, 128'h00010203_05060704_0A0B0809_0F0C0D0E);
        tick();
        check("fwd_drain", po_valid, 0);
        check("fwd_count", po_count, 1);

        pi_valid = 1'b1; pi_inv = 1'b1;
        tick();
        pi_valid = 1'b0;
        check("inv_valid", po_valid, 1);
        check("inv_out", po_out, 128'h00010203_07040506_0A0B0809_0D0E0F0C);
        tick();
        check("inv_count", po_count, 2);

        // NB=8 forward: rows 2/3 use offsets 3/4
        for (int b = 0; b < 32; b++) v8_pi_in[255-8*b -: 8] = 8'(b);
        v8_pi_ready = 1'b1; v8_pi_valid = 1'b1; v8_pi_inv = 1'b0;
        #1;
        check("nb8_ready", v8_po_ready, 1);
        tick();
        v8_pi_valid = 1'b0;
        check("nb8_valid", v8_po_valid, 1);
        check("nb8_row2", v8_po_out[127:64], 64'h13141516_17101112);
        check("nb8_row3", v8_po_out[63:0],   64'h1C1D1E1F_18191A1B);
        check("nb8_full", v8_po_out,
              256'h00010203_04050607_090A0B0C_0D0E0F08_13141516_17101112_1C1D1E1F_18191A1B);
        tick();
        check("nb8_count", v8_po_count, 1);

        // 20 back-to-back states
        pi_rst = 1'b0;
        #1;
        check("rst2_count", po_count, 0);
        tick();
        pi_rst = 1'b1;
        tick();
        wait_ready("rdy_stream");
        for (int i = 0; i < 20; i++) begin
            pi_valid = 1'b1; pi_in = gen_state(i); pi_inv = i[0];
            #1;
            check("stream_ready", po_ready, 1);
            if (i > 0) begin
                check("stream_valid", po_valid, 1);
                check("stream_out", po_out, ref_shift(gen_state(i-1), i[0] ^ 1'b1));
            end
            tick();
        end
        pi_valid = 1'b0;
        check("stream_last_valid", po_valid, 1);
        check("stream_last_out", po_out, ref_shift(gen_state(19), 1'b1));
        tick();
        check("stream_drain", po_valid, 0);
        check("stream_count", po_count, 20);

        // Random stalls with scoreboard
        pi_rst = 1'b0;
        tick();
        pi_rst = 1'b1;
        tick();
        sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
        while (recv < 40 && cyc < 800) begin
            pi_ready = 1'($urandom_range(0, 1));
            pi_valid = (sent < 40) && ($urandom_range(0, 3) != 0);
            pi_in    = gen_state(sent + 50);
            pi_inv   = sent[0];
            #1;
            if (prev_stall) begin
                check("stall_valid", po_valid, 1);
                check("stall_hold", po_out, prev_out);
            end
`ifdef SHIFT_ROWS_SKID_EN
            r0 = po_ready;
            pi_ready = ~pi_ready;
            #1;
            check("ready_indep", po_ready, r0);
            pi_ready = ~pi_ready;
            #1;
`endif
            if (po_valid && pi_ready) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_order", po_out, exp_q.pop_front());
                recv++;
            end
            if (pi_valid && po_ready) begin
                exp_q.push_back(ref_shift(pi_in, pi_inv));
                sent++;
            end
            prev_stall = po_valid && !pi_ready;
            prev_out   = po_out;
            cyc++;
            tick();
        end
        pi_valid = 1'b0;
        check("sb_received", recv, 40);
        check("sb_count", po_count, 40);
        check("sb_leftover", exp_q.size(), 0);

        // Reset while holding states (two in the skid build)
        pi_ready = 1'b0; pi_valid = 1'b1; pi_inv = 1'b0; pi_in = gen_state(200);
        #1;
        wait_ready("rdy_hold");
        tick();
        pi_in = gen_state(201);
        tick();
        check("hold_valid", po_valid, 1);
`ifdef SHIFT_ROWS_SKID_EN
        check("skid_full_ready", po_ready, 0);
`endif
        pi_rst = 1'b0; pi_valid = 1'b0;
        #1;
        check("midrst_valid", po_valid, 0);
        check("midrst_count", po_count, 0);
        check("midrst_out", po_out, 0);
        check("midrst_ready", po_ready, 0);
        tick(); tick();
        pi_rst = 1'b1; pi_ready = 1'b1;
        tick();
        wait_ready("rdy_post_rst");
        pi_valid = 1'b1; pi_inv = 1'b1; pi_in = gen_state(300);
        tick();
        pi_valid = 1'b0;
        check("post_rst_valid", po_valid, 1);
        check("post_rst_out", po_out, ref_shift(gen_state(300), 1'b1));
        tick();
        check("post_rst_empty", po_valid, 0);
        check("post_rst_count", po_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
